core_sequencer: RTL and testbench

Host-side run controller for the single-cycle RISC-V core. It sits between the logic-analyzer command bits and the core's control/debug taps. It accepts one command at a time over a valid/ready channel and returns exactly one response per command. It loads instruction RAM slots, holds or releases core reset, gates core execution for N cycles, a single step or until a PC breakpoint, and reads back registers and data memory.

---
 rtl/core_seq_pkg.sv | 35 +++
 rtl/core_sequencer_if.sv | 23 ++
 rtl/core_seq_run_timer.sv | 58 +++++
 rtl/core_sequencer.sv | 178 +++++++++++++++++
 tb/tb_core_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/core_seq_pkg.sv
// Shared opcode, status and state encodings for the core run controller.
package core_seq_pkg;

  typedef enum logic [2:0] {
    OP_LOAD       = 3'd0,
    OP_RUN        = 3'd1,
    OP_STEP       = 3'd2,
    OP_HALT       = 3'd3,
    OP_READ_REG   = 3'd4,
    OP_READ_DRAM  = 3'd5,
    OP_SET_BP     = 3'd6,
    OP_RESET_CORE = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BP      = 2'd1,
    ST_HALT    = 2'd2,
    ST_ILLEGAL = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DONE   = 3'd2,
    S_RDWAIT = 3'd3,
    S_CRST   = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  // An all-ones breakpoint address disables the breakpoint.
  localparam logic [31:0] HALT_NONE  = 32'hFFFF_FFFF;
  localparam logic [31:0] BP_DISABLE = HALT_NONE;

endpackage

// File: rtl/core_sequencer_if.sv
// Host command/response channel of the core run controller.
interface core_sequencer_if;
  import core_seq_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  op_e         cmd_op;
  logic [31:0] cmd_arg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_status
  );
endinterface

// File: rtl/core_seq_run_timer.sv
// Execution gate for RUN/STEP: remaining-count, first-cycle breakpoint exemption
// and stop-cause selection.
module core_seq_run_timer
  import core_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_count,
  input  logic        i_ignore_bp,
  input  logic        i_active,
  input  logic        i_halt,
  input  logic        i_bp_en,
  input  logic [31:0] i_bp_addr,
  input  logic [31:0] i_core_pc,
  output logic        o_clk_en,
  output logic        o_exit,
  output status_e     o_cause
);

  logic [31:0] r_remaining;
  logic        r_first;
  logic        r_ignore_bp;
  logic        w_bp_hit;
  logic        w_halt;
  logic        w_last;

  // The first cycle never breaks, so a run can resume from a breakpoint PC.
  assign w_bp_hit = i_active && i_bp_en && !r_ignore_bp && !r_first &&
                    (i_core_pc == i_bp_addr);
  assign w_halt   = i_active && i_halt;
  assign o_clk_en = i_active && !w_bp_hit && !w_halt;
  assign w_last   = o_clk_en && (r_remaining == 32'd1);
  assign o_exit   = w_last || w_bp_hit || w_halt;

  always_comb begin
    o_cause = ST_OK;
    if (w_bp_hit)    o_cause = ST_BP;
    else if (w_halt) o_cause = ST_HALT;
  end

  // A zero count means unbounded, so it is held rather than decremented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= 32'd0;
      r_first     <= 1'b0;
      r_ignore_bp <= 1'b0;
    end else if (i_start) begin
      r_remaining <= i_count;
      r_first     <= 1'b1;
      r_ignore_bp <= i_ignore_bp;
    end else if (i_active) begin
      r_first <= 1'b0;
      if (o_clk_en && r_remaining != 32'd0) r_remaining <= r_remaining - 32'd1;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Host-side run controller: one command in, one response out, driving the
// core's reset, clock-enable, instruction-load and readback taps.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int IRAM_DEPTH      = 16,
  parameter int READ_LAT        = 1,
  parameter int CORE_RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  core_sequencer_if.slave  bus,
  output logic             core_rst_n,
  output logic             core_clk_en,
  input  logic [31:0]      core_pc,
  output logic             iram_write,
  output logic [3:0]       iram_select,
  output logic [31:0]      iram_data,
  output logic [4:0]       reg_select,
  input  logic [31:0]      reg_data,
  output logic [7:0]       dram_select,
  input  logic [31:0]      dram_data
);

  localparam int PTR_W = (IRAM_DEPTH > 1) ? $clog2(IRAM_DEPTH) : 1;

  state_e             r_state, w_state_next;
  op_e                w_op;
  logic               w_accept;
  logic               w_run_start;
  logic               w_exit;
  status_e            w_cause;
  logic [PTR_W-1:0]   r_ptr;
  logic [31:0]        r_bp_addr;
  logic               r_bp_en;
  logic [31:0]        r_rsp_data;
  status_e            r_rsp_status;
  logic               r_core_rst_n;
  logic               r_iram_write;
  logic [3:0]         r_iram_select;
  logic [31:0]        r_iram_data;
  logic [4:0]         r_reg_select;
  logic [7:0]         r_dram_select;
  logic [7:0]         r_wait;
  logic               r_rd_dram;

  assign w_op        = bus.cmd_op;
  assign w_accept    = bus.cmd_valid && (r_state == S_IDLE);
  assign w_run_start = w_accept && (w_op == OP_RUN || w_op == OP_STEP);

  core_seq_run_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_run_start),
    .i_count     ((w_op == OP_STEP) ? 32'd1 : bus.cmd_arg),
    .i_ignore_bp (w_op == OP_STEP),
    .i_active    (r_state == S_RUN),
    .i_halt      (bus.cmd_valid && (w_op == OP_HALT)),
    .i_bp_en     (r_bp_en),
    .i_bp_addr   (r_bp_addr),
    .i_core_pc   (core_pc),
    .o_clk_en    (core_clk_en),
    .o_exit      (w_exit),
    .o_cause     (w_cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // During RUN only a HALT is accepted, and readiness follows the opcode alone.
  always_comb begin
    w_state_next  = r_state;
    bus.cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (w_accept) begin
          case (w_op)
            OP_RUN, OP_STEP:           w_state_next = S_RUN;
            OP_READ_REG, OP_READ_DRAM: w_state_next = S_RDWAIT;
            OP_RESET_CORE:             w_state_next = S_CRST;
            default:                   w_state_next = S_RESP;
          endcase
        end
      end
      S_RUN: begin
        bus.cmd_ready = (w_op == OP_HALT);
        if (w_exit) w_state_next = S_DONE;
      end
      S_DONE:   w_state_next = S_RESP;
      S_RDWAIT: if (r_wait == 8'd0) w_state_next = S_RESP;
      S_CRST:   if (r_wait == 8'd0) w_state_next = S_RESP;
      S_RESP:   if (bus.rsp_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_bp_addr     <= BP_DISABLE;
      r_bp_en       <= 1'b0;
      r_rsp_data    <= 32'd0;
      r_rsp_status  <= ST_OK;
      r_core_rst_n  <= 1'b0;
      r_iram_write  <= 1'b0;
      r_iram_select <= 4'd0;
      r_iram_data   <= 32'd0;
      r_reg_select  <= 5'd0;
      r_dram_select <= 8'd0;
      r_wait        <= 8'd0;
      r_rd_dram     <= 1'b0;
    end else begin
      r_iram_write <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rsp_status <= ST_OK;
          case (w_op)
            OP_LOAD: begin
              r_iram_write  <= 1'b1;
              r_iram_select <= 4'(r_ptr);
              r_iram_data   <= bus.cmd_arg;
              r_rsp_data    <= 32'(r_ptr);
              r_ptr         <= (r_ptr == PTR_W'(IRAM_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
            end
            OP_RUN, OP_STEP: r_core_rst_n <= 1'b1;
            OP_HALT: begin
              r_rsp_data   <= core_pc;
              r_rsp_status <= ST_HALT;
            end
            OP_READ_REG: begin
              r_reg_select <= bus.cmd_arg[4:0];
              r_rd_dram    <= 1'b0;
              r_wait       <= 8'(READ_LAT - 1);
            end
            OP_READ_DRAM: begin
              r_dram_select <= bus.cmd_arg[7:0];
              r_rd_dram     <= 1'b1;
              r_wait        <= 8'(READ_LAT - 1);
            end
            OP_SET_BP: begin
              r_bp_addr  <= bus.cmd_arg;
              r_bp_en    <= (bus.cmd_arg != BP_DISABLE);
              r_rsp_data <= bus.cmd_arg;
            end
            default: begin
              r_core_rst_n <= 1'b0;
              r_ptr        <= '0;
              r_rsp_data   <= 32'd0;
              r_wait       <= 8'(CORE_RST_CYCLES - 1);
            end
          endcase
        end
        S_RUN:  if (w_exit) r_rsp_status <= w_cause;
        S_DONE: r_rsp_data <= core_pc;
        S_RDWAIT: begin
          if (r_wait == 8'd0) r_rsp_data <= r_rd_dram ? dram_data : reg_data;
          else                r_wait     <= r_wait - 8'd1;
        end
        S_CRST: if (r_wait != 8'd0) r_wait <= r_wait - 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_status = r_rsp_status;
  assign core_rst_n     = r_core_rst_n;
  assign iram_write     = r_iram_write;
  assign iram_select    = r_iram_select;
  assign iram_data      = r_iram_data;
  assign reg_select     = r_reg_select;
  assign dram_select    = r_dram_select;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a tiny sequential-PC core model.
module tb_core_sequencer;
  import core_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_rst_n, core_clk_en, iram_write;
  logic [3:0]  iram_select;
  logic [31:0] iram_data, reg_data, dram_data;
  logic [31:0] core_pc = 32'd0;
  logic [4:0]  reg_select;
  logic [7:0]  dram_select;
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  int          en_base = 0;
  logic        seen;

  always #5 clk = ~clk;

  core_sequencer_if bus ();

  core_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .core_rst_n  (core_rst_n),
    .core_clk_en (core_clk_en),
    .core_pc     (core_pc),
    .iram_write  (iram_write),
    .iram_select (iram_select),
    .iram_data   (iram_data),
    .reg_select  (reg_select),
    .reg_data    (reg_data),
    .dram_select (dram_select),
    .dram_data   (dram_data)
  );

  always @(posedge clk) begin
    if (!core_rst_n)     core_pc <= 32'd0;
    else if (core_clk_en) core_pc <= core_pc + 32'd4;
  end

  always @(negedge clk) if (core_clk_en) en_cnt <= en_cnt + 1;

  assign reg_data  = 32'hA000_0000 | 32'(reg_select);
  assign dram_data = 32'hD000_0000 | 32'(dram_select);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called one step after a rising edge with the DUT idle; returns at T+1.
  task automatic issue(input op_e op, input logic [31:0] arg);
    en_base       = en_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic finish(input string tag, input int lat0, input int exp_lat,
                        input logic [31:0] exp_data, input logic [1:0] exp_st,
                        input int exp_en);
    int lat;
    lat = lat0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, bus.rsp_data, exp_data);
    check({tag, "_status"}, 32'(bus.rsp_status), 32'(exp_st));
    check({tag, "_clk_en"}, 32'(en_cnt - en_base), 32'(exp_en));
    $display("txn %s lat=%0d data=%h status=%0d enables=%0d",
             tag, lat, bus.rsp_data, bus.rsp_status, en_cnt - en_base);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] slot, input logic [31:0] word);
    issue(OP_LOAD, word);
    check("iram_write", 32'(iram_write), 32'd1);
    check("iram_select", 32'(iram_select), slot);
    check("iram_data", iram_data, word);
    finish("load", 1, 1, slot, 2'd0, 0);
    check("iram_write_pulse", 32'(iram_write), 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_arg   = 32'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_clk_en", 32'(core_clk_en), 32'd0);
    check("rst_iram_write", 32'(iram_write), 32'd0);
    check("rst_selects", {iram_select, reg_select, dram_select}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(32'd0, 32'h0050_0093);
    do_load(32'd1, 32'h0010_8113);
    for (int i = 2; i <= 16; i++) do_load(32'(i % 16), 32'h0000_0013 + 32'(i));

    check("parked", 32'(core_rst_n), 32'd0);
    issue(OP_RUN, 32'd3);
    check("core_rst_rise", 32'(core_rst_n), 32'd1);
    finish("run3", 1, 5, 32'd12, 2'd0, 3);

    issue(OP_RESET_CORE, 32'd0);
    check("crst_low", 32'(core_rst_n), 32'd0);
    finish("reset_core", 1, 3, 32'd0, 2'd0, 0);
    check("crst_parked", 32'(core_rst_n), 32'd0);
    do_load(32'd0, 32'h0000_0073);

    issue(OP_SET_BP, 32'd8);
    finish("set_bp", 1, 1, 32'd8, 2'd0, 0);
    issue(OP_RUN, 32'd0);
    finish("run_bp", 1, 5, 32'd8, 2'd1, 2);
    issue(OP_STEP, 32'd0);
    finish("step", 1, 3, 32'd12, 2'd0, 1);
    issue(OP_SET_BP, 32'hFFFF_FFFF);
    finish("clr_bp", 1, 1, 32'hFFFF_FFFF, 2'd0, 0);

    issue(OP_RUN, 32'd0);
    bus.cmd_op = OP_LOAD;
    @(negedge clk);
    check("run_ready_other", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    bus.cmd_op = OP_HALT;
    @(negedge clk);
    check("run_ready_halt", 32'(bus.cmd_ready), 32'd1);
    check("run_en_novalid", 32'(core_clk_en), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("halt_accept_en", 32'(core_clk_en), 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    finish("run_halt", 6, 7, 32'd28, 2'd2, 4);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen = seen | bus.rsp_valid; end
    check("single_rsp", 32'(seen), 32'd0);
    @(posedge clk); #1;

    issue(OP_HALT, 32'd0);
    finish("halt_idle", 1, 1, 32'd28, 2'd2, 0);
    issue(OP_READ_REG, 32'd1);
    finish("read_reg", 1, 2, 32'hA000_0001, 2'd0, 0);
    check("reg_select_hold", 32'(reg_select), 32'd1);
    issue(OP_READ_DRAM, 32'h0000_0004);
    finish("read_dram", 1, 2, 32'hD000_0004, 2'd0, 0);
    check("dram_select_hold", 32'(dram_select), 32'd4);

    issue(OP_RUN, 32'd0);
    @(negedge clk);
    check("pre_rst_en", 32'(core_clk_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_en", 32'(core_clk_en), 32'd0);
    check("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("async_core_rst_n", 32'(core_rst_n), 32'd0);
    check("async_rsp_data", bus.rsp_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    do_load(32'd0, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
